// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the oversampled UART blocks
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        BRK_WAIT = 3'd5
    } rx_state_t;

    // Bit positions inside Rx_Error; the downstream FIFO/BIST logic depends on them.
    localparam int ERR_BREAK  = 0;
    localparam int ERR_PARITY = 1;
    localparam int ERR_FRAME  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, one pulse every TICK_DIV clocks
module uart_baud_tick #(
    parameter int TICK_DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    always_comb begin
        wrap  = (cnt_q == CNT_LAST);
        cnt_d = cnt_q + 1'b1;
        if (restart_i || wrap) begin
            cnt_d = '0;
        end
    end

    // A restart realigns the phase, so the wrap in that cycle is not a tick.
    assign tick_o = wrap & ~restart_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - 16x oversampled UART receiver with majority vote and holding register
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic [1:0]           Parity_Mode,
    input  logic                 Stop_Sel,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Valid,
    input  logic                 Data_Ready,
    output logic [2:0]           Rx_Error,
    output logic                 Overrun,
    output logic                 RTS,
    output logic                 Busy
);

    localparam int TICK_DIV = SYSCLK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int SCW      = $clog2(OVERSAMPLE);
    localparam int BCW      = $clog2(DATA_BITS + 1);

    localparam logic [SCW-1:0] SC_S0   = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_S1   = SCW'(OVERSAMPLE / 2);
    localparam logic [SCW-1:0] SC_S2   = SCW'(OVERSAMPLE / 2 + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS);

    generate
        if (TICK_DIV < 2) begin : g_bad_div
            $error("uart_rx_os: TICK_DIV must be at least 2");
        end
        if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
            $error("uart_rx_os: OVERSAMPLE must be even and at least 8");
        end
        if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
            $error("uart_rx_os: DATA_BITS must be 5..9");
        end
    endgenerate

    logic       rx_meta_q;
    logic       rxs_q;
    logic       rxs_prev_q;
    logic [1:0] settle_q;

    logic       tick;
    logic       restart;
    logic       start_edge;

    rx_state_t            state_q,    state_d;
    logic [SCW-1:0]       sc_q,       sc_d;
    logic [BCW-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 s0_q,       s0_d;
    logic                 s1_q,       s1_d;
    parity_mode_t         mode_q,     mode_d;
    logic                 stop2_q,    stop2_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_bit_q,  par_bit_d;
    logic                 par_err_q,  par_err_d;
    logic                 frm_err_q,  frm_err_d;

    logic                 commit_q,   commit_d;
    logic [DATA_BITS-1:0] cmt_data_q, cmt_data_d;
    logic [2:0]           cmt_err_q,  cmt_err_d;

    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic [2:0]           err_q,      err_d;
    logic                 valid_q,    valid_d;
    logic                 overrun_q,  overrun_d;
    logic                 rts_q,      rts_d;

    logic samp_lo;
    logic samp_mid;
    logic samp_hi;
    logic wrap;
    logic maj;
    logic has_par;
    logic brk;
    logic frm;
    logic accept;

    // The settle count hides the reset-value-to-line transition of the synchroniser,
    // so a line that is already low at reset release does not look like a start edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            settle_q   <= 2'd0;
        end else begin
            rx_meta_q  <= Rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    assign start_edge = (settle_q == 2'd3) & rxs_prev_q & ~rxs_q;
    assign restart    = (state_q == IDLE) & start_edge;

    uart_baud_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i     (Clk),
        .rst_i     (Rst),
        .restart_i (restart),
        .tick_o    (tick)
    );

    assign samp_lo  = tick & (sc_q == SC_S0);
    assign samp_mid = tick & (sc_q == SC_S1);
    assign samp_hi  = tick & (sc_q == SC_S2);
    assign wrap     = tick & (sc_q == SC_LAST);
    assign maj      = maj3(s0_q, s1_q, rxs_q);
    assign has_par  = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);

    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        mode_d     = mode_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        par_bit_d  = par_bit_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        commit_d   = 1'b0;
        cmt_data_d = cmt_data_q;
        cmt_err_d  = cmt_err_q;
        brk        = 1'b0;
        frm        = frm_err_q;

        if (tick) begin
            sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
        end
        if (samp_lo) begin
            s0_d = rxs_q;
        end
        if (samp_mid) begin
            s1_d = rxs_q;
        end

        case (state_q)
            IDLE: begin
                sc_d = '0;
                if (start_edge) begin
                    state_d    = START;
                    mode_d     = parity_mode_t'(Parity_Mode);
                    stop2_d    = Stop_Sel;
                    bit_cnt_d  = '0;
                    shift_d    = '0;
                    stop_idx_d = 1'b0;
                    par_bit_d  = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            START: begin
                if (samp_hi && maj) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (samp_hi) begin
                    shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (wrap && (bit_cnt_q == BC_LAST)) begin
                    state_d = has_par ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (samp_hi) begin
                    par_bit_d = maj;
                    par_err_d = (^shift_q) ^ maj ^ (mode_q == PAR_ODD);
                end
                if (wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (samp_hi) begin
                    frm = frm_err_q | ~maj;
                    brk = ~maj & ~stop_idx_q & (shift_q == '0) & ~(has_par & par_bit_q);
                    if (brk) begin
                        commit_d              = 1'b1;
                        cmt_data_d            = shift_q;
                        cmt_err_d             = 3'b000;
                        cmt_err_d[ERR_BREAK]  = 1'b1;
                        cmt_err_d[ERR_FRAME]  = 1'b1;
                        state_d               = BRK_WAIT;
                    end else if (stop_idx_q == stop2_q) begin
                        commit_d              = 1'b1;
                        cmt_data_d            = shift_q;
                        cmt_err_d             = 3'b000;
                        cmt_err_d[ERR_FRAME]  = frm;
                        cmt_err_d[ERR_PARITY] = par_err_q;
                        state_d               = IDLE;
                    end else begin
                        frm_err_d  = frm;
                        stop_idx_d = 1'b1;
                    end
                end
            end
            BRK_WAIT: begin
                sc_d = '0;
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = valid_q & Data_Ready;

    // Accept and commit in one cycle behave as accept-then-load, so no overrun.
    always_comb begin
        data_out_d = data_out_q;
        err_d      = err_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        if (commit_q) begin
            if (!valid_q || accept) begin
                data_out_d = cmt_data_q;
                err_d      = cmt_err_q;
                valid_d    = 1'b1;
                if (accept) begin
                    overrun_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        rts_d = ~valid_d;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            sc_q       <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            mode_q     <= PAR_NONE;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            commit_q   <= 1'b0;
            cmt_data_q <= '0;
            cmt_err_q  <= '0;
            data_out_q <= '0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            rts_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            mode_q     <= mode_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            commit_q   <= commit_d;
            cmt_data_q <= cmt_data_d;
            cmt_err_q  <= cmt_err_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            rts_q      <= rts_d;
        end
    end

    assign Data_Out   = data_out_q;
    assign Data_Valid = valid_q;
    assign Rx_Error   = err_q;
    assign Overrun    = overrun_q;
    assign RTS        = rts_q;
    assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed scoreboard bench for uart_rx_os
module tb_uart_rx_os;

    localparam int SYS  = 1536000;
    localparam int BAUD = 9600;
    localparam int OS   = 16;
    localparam int DB   = 8;
    localparam int BIT  = 160;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Rx;
    logic [1:0]    Parity_Mode;
    logic          Stop_Sel;
    logic [DB-1:0] Data_Out;
    logic          Data_Valid;
    logic          Data_Ready;
    logic [2:0]    Rx_Error;
    logic          Overrun;
    logic          RTS;
    logic          Busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [DB-1:0] data;
        logic [2:0]    err;
    } exp_t;

    exp_t sb[$];

    uart_rx_os #(
        .SYSCLK_RATE (SYS),
        .BAUD_RATE   (BAUD),
        .OVERSAMPLE  (OS),
        .DATA_BITS   (DB)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Rx          (Rx),
        .Parity_Mode (Parity_Mode),
        .Stop_Sel    (Stop_Sel),
        .Data_Out    (Data_Out),
        .Data_Valid  (Data_Valid),
        .Data_Ready  (Data_Ready),
        .Rx_Error    (Rx_Error),
        .Overrun     (Overrun),
        .RTS         (RTS),
        .Busy        (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_err(input logic [DB-1:0] d, input logic [1:0] pm,
                                             input logic pbit, input logic stop_v);
        logic has_par;
        logic perr;
        has_par = (pm == 2'b01) || (pm == 2'b10);
        perr    = has_par && ((^d ^ pbit) != (pm == 2'b10));
        if ((d == '0) && (!has_par || !pbit) && !stop_v) begin
            return 3'b101;
        end
        return {~stop_v, perr, 1'b0};
    endfunction

    task automatic send_bit(input logic v);
        Rx = v;
        repeat (BIT) @(posedge Clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic ss,
                              input logic pbit, input logic stop_v, input logic push);
        Parity_Mode = pm;
        Stop_Sel    = ss;
        if (push) begin
            sb.push_back('{data: d, err: model_err(d, pm, pbit, stop_v)});
        end
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) begin
            send_bit(d[i]);
        end
        if ((pm == 2'b01) || (pm == 2'b10)) begin
            send_bit(pbit);
        end
        send_bit(stop_v);
        if (ss) begin
            send_bit(1'b1);
        end
    endtask

    task automatic expect_frame(input string tag);
        exp_t e;
        int   n;
        n = 0;
        @(negedge Clk);
        while (!Data_Valid && (n < 4 * BIT)) begin
            @(negedge Clk);
            n++;
        end
        check({tag, " valid"}, Data_Valid, 1);
        if (sb.size() == 0) begin
            check({tag, " scoreboard"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({tag, " data"}, Data_Out, e.data);
            check({tag, " err"}, Rx_Error, e.err);
        end
    endtask

    task automatic accept();
        @(negedge Clk);
        Data_Ready = 1'b1;
        @(negedge Clk);
        Data_Ready = 1'b0;
    endtask

    initial begin
        Rst         = 1'b1;
        Rx          = 1'b1;
        Parity_Mode = 2'b00;
        Stop_Sel    = 1'b0;
        Data_Ready  = 1'b0;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        check("rst data", Data_Out, 0);
        check("rst valid", Data_Valid, 0);
        check("rst err", Rx_Error, 0);
        check("rst overrun", Overrun, 0);
        check("rst rts", RTS, 1);
        check("rst busy", Busy, 0);
        Rst = 1'b0;
        repeat (20) @(posedge Clk);

        send_frame(8'hA5, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
        expect_frame("t1");
        check("t1 rts", RTS, 0);
        check("t1 overrun", Overrun, 0);
        accept();
        check("t1 valid after accept", Data_Valid, 0);
        check("t1 rts after accept", RTS, 1);

        send_frame(8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_frame("t2");
        accept();

        send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_frame("t3 frame");
        accept();
        send_bit(1'b1);
        sb.push_back('{data: '0, err: model_err('0, 2'b00, 1'b0, 1'b0)});
        Rx = 1'b0;
        repeat (12 * BIT) @(posedge Clk);
        expect_frame("t3 break");
        check("t3 busy in brk", Busy, 1);
        accept();
        repeat (2 * BIT) @(posedge Clk);
        @(negedge Clk);
        check("t3 no frame while low", Data_Valid, 0);
        check("t3 still brk_wait", Busy, 1);
        Rx = 1'b1;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        check("t3 busy after release", Busy, 0);
        check("t3 valid after release", Data_Valid, 0);

        send_bit(1'b1);
        Rx = 1'b0;
        repeat (40) @(posedge Clk);
        Rx = 1'b1;
        @(negedge Clk);
        check("t4 busy on glitch", Busy, 1);
        repeat (BIT) @(posedge Clk);
        @(negedge Clk);
        check("t4 busy returns", Busy, 0);
        check("t4 no valid", Data_Valid, 0);

        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_frame("t5 first");
        check("t5 overrun", Overrun, 1);
        accept();
        check("t5 overrun cleared", Overrun, 0);
        check("t5 valid cleared", Data_Valid, 0);
        send_frame(8'h33, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_frame("t5 third");
        check("t5 overrun after third", Overrun, 0);

        Rx = 1'b0;
        repeat (BIT) @(posedge Clk);
        for (int i = 0; i < 4; i++) begin
            send_bit(((8'h55 >> i) & 8'h01) != 0);
        end
        Rx = 1'b1;
        repeat (BIT / 2) @(posedge Clk);
        @(negedge Clk);
        check("t6 busy mid frame", Busy, 1);
        #2 Rst = 1'b1;
        #1;
        check("t6 rst data", Data_Out, 0);
        check("t6 rst valid", Data_Valid, 0);
        check("t6 rst err", Rx_Error, 0);
        check("t6 rst overrun", Overrun, 0);
        check("t6 rst rts", RTS, 1);
        check("t6 rst busy", Busy, 0);
        Rx = 1'b0;
        repeat (3) @(posedge Clk);
        Rst = 1'b0;
        repeat (2 * BIT) @(posedge Clk);
        @(negedge Clk);
        check("t6 low at release no start", Busy, 0);
        check("t6 low at release no valid", Data_Valid, 0);
        Rx = 1'b1;
        repeat (BIT) @(posedge Clk);
        send_frame(8'h66, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_frame("t6 after reset");
        check("t6 overrun", Overrun, 0);
        check("scoreboard empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
